// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and flag-bank selects for alu_seq
// Optional feature macro: ALU_SEQ_MUL_EN (adds the MUL state encoding).
package alu_pkg;

   localparam logic [3:0] OP_PASS   = 4'd0;
   localparam logic [3:0] OP_NOT    = 4'd1;
   localparam logic [3:0] OP_ADD    = 4'd2;
   localparam logic [3:0] OP_SUB    = 4'd3;
   localparam logic [3:0] OP_AND    = 4'd4;
   localparam logic [3:0] OP_OR     = 4'd5;
   localparam logic [3:0] OP_NEG    = 4'd6;
   localparam logic [3:0] OP_NEGSEL = 4'd7;
   localparam logic [3:0] OP_XOR    = 4'd8;
   localparam logic [3:0] OP_SHL    = 4'd9;
   localparam logic [3:0] OP_SHR    = 4'd10;
   localparam logic [3:0] OP_SRA    = 4'd11;
   localparam logic [3:0] OP_MUL    = 4'd12;

   localparam logic BANK_NORMAL = 1'b0;
   localparam logic BANK_INTR   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1
`ifdef ALU_SEQ_MUL_EN
      ,
      ST_MUL  = 2'd2
`endif
   } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result bundle between an ALU client and alu_seq
// Ports: master drives a, b, op, s_inm, interruption, start;
//        slave drives busy, done, y, carry, overflow, zero, carry_intr, zero_intr.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic             s_inm;
   logic             interruption;
   logic             start;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] y;
   logic             carry;
   logic             overflow;
   logic             zero;
   logic             carry_intr;
   logic             zero_intr;

   modport master (
      output a, b, op, s_inm, interruption, start,
      input  busy, done, y, carry, overflow, zero, carry_intr, zero_intr
   );

   modport slave (
      input  a, b, op, s_inm, interruption, start,
      output busy, done, y, carry, overflow, zero, carry_intr, zero_intr
   );
endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - unsigned shift-add multiplier, one multiplier bit per cycle
// Ports: clk, reset_n (async active-low); start loads a/b; done pulses one cycle
//        after the WIDTH-th iteration; product holds the full 2*WIDTH result.
module alu_mul_iter #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               running;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else if (start) begin
         product <= '0;
         mcand   <= {{WIDTH{1'b0}}, a};
         mplier  <= b;
         cnt     <= CW'(WIDTH);
         running <= 1'b1;
         done    <= 1'b0;
      end else if (running) begin
         if (mplier[0]) begin
            product <= product + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
         // Last partial product lands on the same edge done is raised.
         if (cnt == CW'(1)) begin
            running <= 1'b0;
            done    <= 1'b1;
         end
      end else begin
         done <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with start/busy/done handshake and two flag banks
// Ports: clk, reset_n (async active-low), bus (alu_seq_if.slave: operands, op,
//        s_inm, interruption, start in; busy, done, y and five flags out).
// Optional feature macro: ALU_SEQ_MUL_EN (op 12 = iterative MUL; reserved otherwise).
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic      clk,
   input  logic      reset_n,
   alu_seq_if.slave  bus
);
   localparam int SW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           state;
   logic [WIDTH-1:0] a_r, b_r;
   logic [3:0]       op_r;
   logic             s_inm_r, intr_r;
   logic             busy_r, done_r;
   logic [WIDTH-1:0] y_r;
   logic             c_r, v_r, z_r, ci_r, zi_r;

   logic [WIDTH-1:0] res_y;
   logic             res_c, res_v, res_upd, finish;
   logic [WIDTH:0]   sum, shl_t, shr_t;
   logic [WIDTH-1:0] minuend, subtrahend, diff, neg_src;
   logic [SW-1:0]    sh;

`ifdef ALU_SEQ_MUL_EN
   logic               mul_start, mul_done;
   logic [2*WIDTH-1:0] product;

   assign mul_start = (state == ST_IDLE) && bus.start && (bus.op == OP_MUL);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mul_start),
      .a       (bus.a),
      .b       (bus.b),
      .done    (mul_done),
      .product (product)
   );

   assign finish = (state == ST_EXEC) || ((state == ST_MUL) && mul_done);
`else
   assign finish = (state == ST_EXEC);
`endif

   always_comb begin
      sh         = b_r[SW-1:0];
      sum        = {1'b0, a_r} + {1'b0, b_r};
      minuend    = s_inm_r ? b_r : a_r;
      subtrahend = s_inm_r ? a_r : b_r;
      diff       = minuend - subtrahend;
      neg_src    = s_inm_r ? a_r : b_r;
      // Extra guard bit catches the last bit shifted out; it stays 0 for sh=0.
      shl_t      = {1'b0, a_r} << sh;
      shr_t      = {a_r, 1'b0} >> sh;
      res_y      = '0;
      res_c      = 1'b0;
      res_v      = 1'b0;
      res_upd    = 1'b1;
      case (op_r)
         OP_PASS: begin
            res_y = a_r;
            res_c = res_y[WIDTH-1];
         end
         OP_NOT: begin
            res_y = ~a_r;
            res_c = res_y[WIDTH-1];
         end
         OP_ADD: begin
            res_y = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
         end
         OP_SUB: begin
            res_y = diff;
            res_c = minuend < subtrahend;
            res_v = (minuend[WIDTH-1] != subtrahend[WIDTH-1]) && (diff[WIDTH-1] != minuend[WIDTH-1]);
         end
         OP_AND: begin
            res_y = a_r & b_r;
            res_c = res_y[WIDTH-1];
         end
         OP_OR: begin
            res_y = a_r | b_r;
            res_c = res_y[WIDTH-1];
         end
         OP_XOR: begin
            res_y = a_r ^ b_r;
            res_c = res_y[WIDTH-1];
         end
         OP_NEG: begin
            res_y = -a_r;
            res_c = res_y[WIDTH-1];
            res_v = (a_r == MIN_NEG);
         end
         OP_NEGSEL: begin
            res_y = -neg_src;
            res_c = res_y[WIDTH-1];
            res_v = (neg_src == MIN_NEG);
         end
         OP_SHL: begin
            res_y = shl_t[WIDTH-1:0];
            res_c = shl_t[WIDTH];
         end
         OP_SHR: begin
            res_y = a_r >> sh;
            res_c = shr_t[0];
         end
         OP_SRA: begin
            res_y = $signed(a_r) >>> sh;
            res_c = shr_t[0];
         end
`ifdef ALU_SEQ_MUL_EN
         OP_MUL: begin
            res_y = product[WIDTH-1:0];
            res_v = |product[2*WIDTH-1:WIDTH];
            res_c = res_v;
         end
`else
         OP_MUL: begin
            res_upd = 1'b0;
         end
`endif
         default: begin
            res_upd = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         y_r     <= '0;
         c_r     <= 1'b0;
         v_r     <= 1'b0;
         z_r     <= 1'b0;
         ci_r    <= 1'b0;
         zi_r    <= 1'b0;
         a_r     <= '0;
         b_r     <= '0;
         op_r    <= OP_PASS;
         s_inm_r <= 1'b0;
         intr_r  <= BANK_NORMAL;
      end else begin
         done_r <= 1'b0;
         if (state == ST_IDLE) begin
            if (bus.start) begin
               a_r     <= bus.a;
               b_r     <= bus.b;
               op_r    <= bus.op;
               s_inm_r <= bus.s_inm;
               intr_r  <= bus.interruption;
               busy_r  <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
               if (bus.op == OP_MUL) begin
                  state <= ST_MUL;
               end else begin
                  state <= ST_EXEC;
               end
`else
               state <= ST_EXEC;
`endif
            end
         end else if (finish) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            y_r    <= res_y;
            if (res_upd) begin
               if (intr_r == BANK_INTR) begin
                  ci_r <= res_c;
                  zi_r <= (res_y == '0);
               end else begin
                  c_r <= res_c;
                  v_r <= res_v;
                  z_r <= (res_y == '0);
               end
            end
         end
      end
   end

   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.y          = y_r;
   assign bus.carry      = c_r;
   assign bus.overflow   = v_r;
   assign bus.zero       = z_r;
   assign bus.carry_intr = ci_r;
   assign bus.zero_intr  = zi_r;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (WIDTH=16), directed vectors
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] y;
      logic         c, v, z, ci, zi;
      int           acc;
      int           lat;
      string        name;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse consumes exactly one expected entry.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && bus.done) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got done with y=%0h expected no pending op", bus.y);
            end else begin
               mon_e = sb.pop_front();
               check({mon_e.name, "_y"},          bus.y,          mon_e.y);
               check({mon_e.name, "_carry"},      bus.carry,      mon_e.c);
               check({mon_e.name, "_overflow"},   bus.overflow,   mon_e.v);
               check({mon_e.name, "_zero"},       bus.zero,       mon_e.z);
               check({mon_e.name, "_carry_intr"}, bus.carry_intr, mon_e.ci);
               check({mon_e.name, "_zero_intr"},  bus.zero_intr,  mon_e.zi);
               check({mon_e.name, "_latency"},    cyc - mon_e.acc, mon_e.lat);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(string name, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                        logic s, logic intr, bit push, logic [W-1:0] ey,
                        logic ec, logic ev, logic ez, logic eci, logic ezi, int lat);
      int guard = 0;
      while (bus.busy && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (bus.busy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_wait: busy got 1 expected 0", name);
      end
      bus.op           = op;
      bus.a            = a;
      bus.b            = b;
      bus.s_inm        = s;
      bus.interruption = intr;
      bus.start        = 1'b1;
      if (push) sb.push_back('{ey, ec, ev, ez, eci, ezi, cyc + 1, lat, name});
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic check_cleared(string tag);
      check({tag, "_busy"},       bus.busy,       1'b0);
      check({tag, "_done"},       bus.done,       1'b0);
      check({tag, "_y"},          bus.y,          '0);
      check({tag, "_carry"},      bus.carry,      1'b0);
      check({tag, "_overflow"},   bus.overflow,   1'b0);
      check({tag, "_zero"},       bus.zero,       1'b0);
      check({tag, "_carry_intr"}, bus.carry_intr, 1'b0);
      check({tag, "_zero_intr"},  bus.zero_intr,  1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time expired expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      bus.start = 1'b0;
      bus.op = OP_PASS;
      bus.a = '0;
      bus.b = '0;
      bus.s_inm = 1'b0;
      bus.interruption = 1'b0;
      repeat (3) @(negedge clk);
      check_cleared("reset");
      reset_n = 1'b1;

      //     name      op         a        b        s     intr  push  y        c     v     z     ci    zi    lat
      issue("add_ovf", OP_ADD,    16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      check("busy_after_accept", bus.busy, 1'b1);
      issue("sub_rev", OP_SUB,    16'h0005, 16'h0003, 1'b1, 1'b1, 1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
`ifdef ALU_SEQ_MUL_EN
      issue("mul",     OP_MUL,    16'h0100, 16'h0100, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 17);
      repeat (3) @(negedge clk);
      bus.op = OP_ADD;
      bus.a = 16'h0001;
      bus.b = 16'h0001;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
`else
      issue("op12_rsv", OP_MUL,   16'h0100, 16'h0100, 1'b0, 1'b0, 1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
`endif
      issue("neg_min", OP_NEG,    16'h8000, 16'h0000, 1'b0, 1'b0, 1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
      issue("sra",     OP_SRA,    16'h8001, 16'h0001, 1'b0, 1'b0, 1, 16'hC000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      issue("op13",    4'd13,     16'h1234, 16'h5678, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      issue("op15",    4'd15,     16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      issue("add_cz",  OP_ADD,    16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
      issue("shl1",    OP_SHL,    16'h8001, 16'h0001, 1'b0, 1'b1, 1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
      issue("shr0",    OP_SHR,    16'h0003, 16'h0000, 1'b0, 1'b0, 1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      issue("xor_z",   OP_XOR,    16'h00FF, 16'h00FF, 1'b0, 1'b1, 1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      issue("negsel",  OP_NEGSEL, 16'h0001, 16'h8000, 1'b0, 1'b0, 1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
      issue("shl_msk", OP_SHL,    16'h1234, 16'h0014, 1'b0, 1'b0, 1, 16'h2340, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      issue("sub_ovf", OP_SUB,    16'h8000, 16'h0001, 1'b0, 1'b0, 1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1);

`ifdef ALU_SEQ_MUL_EN
      issue("mul_rst", OP_MUL,    16'h0003, 16'h0005, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      repeat (4) @(negedge clk);
`else
      issue("add_rst", OP_ADD,    16'h0001, 16'h0002, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
`endif
      reset_n = 1'b0;
      #1;
      check_cleared("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      issue("add_post", OP_ADD,   16'h0001, 16'h0001, 1'b0, 1'b0, 1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

      guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);
      check("drain_pending", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal 8..64).
REQ-002 SHALL have port clk  input  1  single system clock, all state rising-edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports a, b  input  WIDTH  operands, sampled on accepted start.
REQ-005 SHALL have port op  input  4  operation code, sampled on accepted start.
REQ-006 SHALL have port s_inm  input  1  operand-order select for SUB/NEGSEL, sampled on accepted start.
REQ-007 SHALL have port interruption  input  1  flag-bank select (1 = interrupt bank), sampled on accepted start.
REQ-008 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-009 SHALL have ports busy, done  output  1  busy high from the cycle after acceptance until done; done is a one-cycle pulse.
REQ-010 SHALL have port y  output  WIDTH  registered result, held until next done.
REQ-011 SHALL have ports carry, overflow, zero  output  1  registered normal-bank flags.
REQ-012 SHALL have ports carry_intr, zero_intr  output  1  registered interrupt-bank flags.

Function
REQ-013 SHALL run FSM IDLE -> EXEC -> IDLE for single-cycle ops, and IDLE -> MUL -> IDLE for MUL; done asserts on the cycle the FSM returns to IDLE.
REQ-014 SHALL give latency: start accepted at edge N -> done/y valid after edge N+1 (single-cycle), after edge N+WIDTH+1 (MUL).
REQ-015 SHALL ignore start while busy=1; operands are not resampled.
REQ-016 SHALL decode op: 0 PASS a; 1 NOT a; 2 ADD a+b; 3 SUB a-b (s_inm=1: b-a); 4 AND; 5 OR; 6 NEG -a; 7 NEGSEL (s_inm=1: -a, else -b); 8 XOR; 9 SHL a by b[log2(WIDTH)-1:0]; 10 SHR logical; 11 SRA; 12 MUL low WIDTH bits of a*b, unsigned; 13-15 reserved.
REQ-017 SHALL compute ADD carry as true bit-WIDTH carry-out; SUB carry as borrow (minuend < subtrahend, unsigned).
REQ-018 SHALL compute shift carry as last bit shifted out, 0 for shift amount 0; logic/PASS/NEG carry = y[WIDTH-1].
REQ-019 SHALL set overflow: ADD/SUB two's-complement signed overflow; NEG/NEGSEL when negated operand = 100..0; MUL when upper WIDTH product bits nonzero; 0 otherwise.
REQ-020 SHALL set zero = (y == 0); MUL carry = MUL overflow.
REQ-021 SHALL update on done only the bank selected by sampled interruption: normal bank writes carry/overflow/zero, interrupt bank writes carry_intr/zero_intr; other bank holds.
REQ-022 SHALL, for reserved ops, produce y=0, pulse done after one cycle, update no flag.
REQ-023 SHALL keep start accepted in the same cycle done pulses only if busy=0 that cycle (back-to-back issue every 2 cycles for single-cycle ops).

Reset
REQ-024 SHALL, on reset_n low at any time including mid-MUL, immediately force IDLE, busy=0, done=0, y=0, all five flags 0; partial product discarded.
REQ-025 SHALL accept first start on the first rising edge with reset_n high.

Configuration
REQ-026 SHALL, with ALU_SEQ_MUL_EN defined, implement op 12 as iterative MUL per REQ-014/019.
REQ-027 SHALL, without ALU_SEQ_MUL_EN, treat op 12 as reserved (REQ-022); MUL state and multiplier absent.

Structure
REQ-028 SHALL place opcode constants, FSM state encodings and flag-bank select constants in shared package alu_pkg.
REQ-029 SHALL implement MUL as sub-module alu_mul_iter (shift-add, one bit per cycle, start/done, 2*WIDTH product), instantiated only under ALU_SEQ_MUL_EN.

Verification
REQ-030 SHALL test WIDTH=16 ADD a=7FFF b=0001 interruption=0 -> y=8000, overflow=1, carry=0, zero=0, done at N+1.
REQ-031 SHALL test SUB s_inm=1 a=0005 b=0003 interruption=1 -> y=FFFE, carry_intr=1, zero_intr=0, normal bank unchanged.
REQ-032 SHALL test MUL a=0100 b=0100 -> y=0000, overflow=1, carry=1, zero=1, done at N+17; start pulsed mid-MUL ignored.
REQ-033 SHALL test NEG a=8000 -> y=8000, overflow=1; SRA a=8001 b=0001 -> y=C000, carry=1.
REQ-034 SHALL test reset_n low during MUL cycle 5 -> busy=0, y=0, flags 0; next ADD 0001+0001 -> y=0002.
REQ-035 SHALL test op 13 -> y=0, done at N+1, all flags unchanged; build without ALU_SEQ_MUL_EN, op 12 same.
